// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states, slice width
// and the nibble-counter width helper.
package adder_pkg;

    localparam int NIB_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_fulladder4.sv
// Combinational 4-bit full-adder slice used once per nibble step.
module fulladder4
    import adder_pkg::*;
(
    input  logic [NIB_BITS-1:0] a,
    input  logic [NIB_BITS-1:0] b,
    input  logic                ci,
    output logic [NIB_BITS-1:0] s,
    output logic                co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIB_BITS{1'b0}}, ci};
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-precision add/subtract computed one nibble per clock through a single
// fulladder4 slice, with valid/ready handshakes on operands and result.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int            NIB  = WIDTH / NIB_BITS;
    localparam int            CW   = cnt_width(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0]          a_sr, b_sr, res_sr, s_q;
    logic                      carry, a_msb, b_msb, co_q, ovf_q;
    logic [CW-1:0]             cnt;
    logic [NIB_BITS-1:0]       sum_nib;
    logic                      fa_co;
    logic [WIDTH-1:0]          b_eff, res_nxt;
    logic [WIDTH+NIB_BITS-1:0] res_cat;
    logic                      in_ready_c, out_valid_c, accept, last_step;

    assign b_eff     = bus.sub ? ~bus.b : bus.b;
    // Sum nibble enters from the top so nibble 0 lands in [3:0] after NIB steps.
    assign res_cat   = {sum_nib, res_sr};
    assign res_nxt   = res_cat[WIDTH+NIB_BITS-1:NIB_BITS];
    assign last_step = (state == RUN) && (cnt == LAST);
    assign accept    = in_ready_c && bus.in_valid;

    fulladder4 u_slice (
        .a  (a_sr[NIB_BITS-1:0]),
        .b  (b_sr[NIB_BITS-1:0]),
        .ci (carry),
        .s  (sum_nib),
        .co (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            s_q    <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            co_q   <= 1'b0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= b_eff;
            carry <= bus.sub | bus.ci;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= b_eff[WIDTH-1];
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> NIB_BITS;
            b_sr   <= b_sr >> NIB_BITS;
            res_sr <= res_nxt;
            carry  <= fa_co;
            cnt    <= cnt + CW'(1);
            // Visible outputs change only when the full result is ready.
            if (last_step) begin
                s_q   <= res_nxt;
                co_q  <= fa_co;
                ovf_q <= (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.s         = s_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder against a cycle-level
// arithmetic model (WIDTH=16) plus directed WIDTH=4 checks.
module tb_nibble_serial_adder;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   chk_en;

    nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
    nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

    nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {ovf, co, s} from plain integer arithmetic.
    function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sub);
        logic [15:0] be;
        int          c, u, sv;
        logic        ov;
        be = sub ? ~b : b;
        c  = sub ? 1 : int'(ci);
        u  = int'(a) + int'(be) + c;
        sv = int'($signed(a)) + int'($signed(be)) + c;
        ov = (sv > 32767) || (sv < -32768);
        return {ov, (u > 65535), u[15:0]};
    endfunction

    // Cycle-level model: busy from accept until result consumed; valid NIB cycles after accept.
    bit          m_busy;
    int          m_left;
    logic [17:0] m_res;
    logic [17:0] m_hold;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_left <= 0;
            m_hold <= '0;
        end else if (!m_busy) begin
            if (bus16.in_valid) begin
                m_res  <= ref16(bus16.a, bus16.b, bus16.ci, bus16.sub);
                m_busy <= 1'b1;
                m_left <= 4;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_hold <= m_res;
        end else if (bus16.out_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  {31'd0, bus16.in_ready},  {31'd0, !m_busy});
            chk("out_valid", {31'd0, bus16.out_valid}, {31'd0, (m_busy && m_left == 0)});
            chk("s",         {16'd0, bus16.s},         {16'd0, m_hold[15:0]});
            chk("co",        {31'd0, bus16.co},        {31'd0, m_hold[16]});
            chk("ovf",       {31'd0, bus16.ovf},       {31'd0, m_hold[17]});
        end
    end

    task automatic wait_idle16();
        int n;
        n = 0;
        @(negedge clk);
        while (m_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {31'd0, m_busy}, 32'd0);
    endtask

    task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                            input logic sub, input logic [15:0] es, input logic eco,
                            input logic eovf, input string nm);
        int n;
        wait_idle16();
        bus16.a = a; bus16.b = b; bus16.ci = ci; bus16.sub = sub;
        bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        bus16.a = $urandom; bus16.b = $urandom; bus16.sub = ~sub;
        for (n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (bus16.out_valid) break;
        end
        chk({nm, "_latency"}, n,                   32'd4);
        chk({nm, "_s"},       {16'd0, bus16.s},    {16'd0, es});
        chk({nm, "_co"},      {31'd0, bus16.co},   {31'd0, eco});
        chk({nm, "_ovf"},     {31'd0, bus16.ovf},  {31'd0, eovf});
    endtask

    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                           input logic sub, input logic [3:0] es, input logic eco,
                           input logic eovf, input string nm);
        int n;
        @(negedge clk);
        bus4.a = a; bus4.b = b; bus4.ci = ci; bus4.sub = sub;
        bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        for (n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (bus4.out_valid) break;
        end
        chk({nm, "_latency"}, n,                 32'd1);
        chk({nm, "_s"},       {28'd0, bus4.s},   {28'd0, es});
        chk({nm, "_co"},      {31'd0, bus4.co},  {31'd0, eco});
        chk({nm, "_ovf"},     {31'd0, bus4.ovf}, {31'd0, eovf});
        @(posedge clk); #1;
        chk({nm, "_ready_after"}, {31'd0, bus4.in_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        checks = 0; failures = 0; chk_en = 1'b0;
        rst = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.ci = 1'b0;
        bus16.sub = 1'b0; bus16.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.ci = 1'b0;
        bus4.sub = 1'b0; bus4.out_ready = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready",  {31'd0, bus16.in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, bus16.out_valid}, 32'd0);
        chk("rst_s",         {16'd0, bus16.s},         32'd0);
        chk("rst_co",        {31'd0, bus16.co},        32'd0);
        chk("rst_ovf",       {31'd0, bus16.ovf},       32'd0);
        chk("rst4_in_ready", {31'd0, bus4.in_ready},   32'd1);
        chk("rst4_out_valid",{31'd0, bus4.out_valid},  32'd0);
        rst = 1'b0;

        run_op16(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
        run_op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ripple");
        run_op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        run_op16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        run_op16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");

        // Backpressure: result held while new operands wait.
        wait_idle16();
        bus16.a = 16'h1234; bus16.b = 16'h4321; bus16.ci = 1'b0; bus16.sub = 1'b0;
        bus16.in_valid = 1'b1; bus16.out_ready = 1'b0;
        @(posedge clk); #1;
        bus16.a = 16'h00AA; bus16.b = 16'h0055;
        for (n = 0; n < 20 && !bus16.out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid", {31'd0, bus16.out_valid}, 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold_ready", {31'd0, bus16.in_ready},  32'd0);
            chk("bp_hold_valid", {31'd0, bus16.out_valid}, 32'd1);
            chk("bp_hold_s",     {16'd0, bus16.s},         32'h5555);
        end
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_post_ready", {31'd0, bus16.in_ready},  32'd1);
        chk("bp_post_valid", {31'd0, bus16.out_valid}, 32'd0);
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        chk("bp_taken", {31'd0, bus16.in_ready}, 32'd0);
        for (n = 0; n < 20 && !bus16.out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_new_s", {16'd0, bus16.s}, 32'h00FF);

        // Abort mid-RUN, then confirm no stale carry.
        wait_idle16();
        bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.ci = 1'b0; bus16.sub = 1'b0;
        bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready",  {31'd0, bus16.in_ready},  32'd1);
        chk("abort_out_valid", {31'd0, bus16.out_valid}, 32'd0);
        chk("abort_s",         {16'd0, bus16.s},         32'd0);
        chk("abort_co",        {31'd0, bus16.co},        32'd0);
        run_op16(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, "after_abort");

        // Random traffic with random backpressure and rare resets.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            rst            = ($urandom_range(0, 149) == 0);
            bus16.in_valid = ($urandom_range(0, 2) != 0);
            bus16.out_ready = $urandom_range(0, 1);
            bus16.a   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            bus16.b   = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
            bus16.ci  = $urandom_range(0, 1);
            bus16.sub = $urandom_range(0, 1);
        end
        @(negedge clk);
        rst = 1'b0; bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
        wait_idle16();

        run_op4(4'hF, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0, "w4_add");
        run_op4(4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1, "w4_ovf");
        run_op4(4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0, "w4_sub");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
